// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: datapath width, reset/bubble constants, opcode map and
// the IF/ID bundle layout.
package riscv_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;   // addi x0,x0,0

    typedef enum logic [6:0] {
        OP_LOAD   = 7'b0000011,
        OP_IMM    = 7'b0010011,
        OP_AUIPC  = 7'b0010111,
        OP_STORE  = 7'b0100011,
        OP_REG    = 7'b0110011,
        OP_LUI    = 7'b0110111,
        OP_BRANCH = 7'b1100011,
        OP_JALR   = 7'b1100111,
        OP_JAL    = 7'b1101111
    } opcode_e;

    typedef struct packed {
        logic [31:0]     instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    localparam int IF_ID_W = $bits(if_id_t);

    function automatic if_id_t if_id_bubble();
        if_id_t b;
        b.instr    = NOP_INSTR;
        b.pc       = '0;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Generic pipeline register with rst > flush > stall > load priority; reset and
// flush both load BUBBLE. Reused for IF/ID and ID/EX.
module if_id_reg #(
    parameter int           W      = 1,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         stall,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst || flush)
            q <= BUBBLE;
        else if (!stall)
            q <= d;
    end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, next-PC select (redirect from EX beats stall), and the
// IF/ID register. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter int                XLEN      = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0]   RESET_PC  = riscv_pkg::RESET_PC[XLEN-1:0],
    parameter logic [31:0]       NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_f,
    input  logic            stall_d,
    input  logic            flush_d,
    input  logic            pc_src_e,
    input  logic [XLEN-1:0] pc_target_e,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] pc_f,
    output logic [31:0]     instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]     fetch_cnt,
    output logic [31:0]     stall_cnt
`endif
);

    localparam int              W        = 32 + 2*XLEN + 1;
    localparam logic [W-1:0]    BUBBLE   = {NOP_INSTR, {(2*XLEN){1'b0}}, 1'b0};
    localparam logic [XLEN-1:0] ALIGN_M  = {{(XLEN-2){1'b1}}, 2'b00};
    localparam logic [XLEN-1:0] FOUR     = XLEN'(4);

    logic [XLEN-1:0] pc_plus4_f;
    logic [XLEN-1:0] pc_next;
    logic [W-1:0]    if_id_d;
    logic [W-1:0]    if_id_q;

    assign pc_plus4_f = pc_f + FOUR;
    assign imem_addr  = pc_f;

    always_comb begin
        pc_next = pc_plus4_f;
        if (pc_src_e)
            pc_next = pc_target_e & ALIGN_M;
        else if (stall_f)
            pc_next = pc_f;
    end

    always_ff @(posedge clk) begin
        if (rst)
            pc_f <= RESET_PC;
        else
            pc_f <= pc_next;
    end

    assign if_id_d = {imem_rdata, pc_f, pc_plus4_f, 1'b1};

    if_id_reg #(
        .W      (W),
        .BUBBLE (BUBBLE)
    ) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .flush (flush_d),
        .stall (stall_d),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign instr_d    = if_id_q[W-1 -: 32];
    assign pc_d       = if_id_q[2*XLEN -: XLEN];
    assign pc_plus4_d = if_id_q[XLEN -: XLEN];
    assign valid_d    = if_id_q[0];

`ifdef FETCH_PERF_CNT_EN
    // A stall cycle that also redirects is not counted: the PC still moves.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (!flush_d && !stall_d)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (stall_f && !pc_src_e)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized + directed bench for fetch_stage against a behavioural model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall_f, stall_d, flush_d, pc_src_e;
    logic [31:0] pc_target_e, imem_addr, imem_rdata, pc_f, instr_d, pc_d, pc_plus4_d;
    logic        valid_d;
    logic [31:0] mem_key;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt, stall_cnt;
`endif

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ mem_key;

    fetch_stage dut (
        .clk(clk), .rst(rst), .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d),
        .pc_src_e(pc_src_e), .pc_target_e(pc_target_e), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d),
        .pc_plus4_d(pc_plus4_d), .valid_d(valid_d)
`ifdef FETCH_PERF_CNT_EN
        , .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: what each register must hold after every edge.
    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d, m_fcnt, m_scnt;
    logic        m_valid;
    bit          m_live = 0;

    always @(posedge clk) begin
        logic [31:0] word;
        word = m_pc ^ mem_key;
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_valid = 0;
            m_fcnt = 0; m_scnt = 0; m_live = 1;
        end else if (m_live) begin
            if (!flush_d && !stall_d) m_fcnt = m_fcnt + 1;
            if (stall_f && !pc_src_e) m_scnt = m_scnt + 1;
            if (flush_d) begin
                m_instr = 32'h13; m_pcd = 0; m_pc4d = 0; m_valid = 0;
            end else if (!stall_d) begin
                m_instr = word; m_pcd = m_pc; m_pc4d = m_pc + 4; m_valid = 1;
            end
            if (pc_src_e)      m_pc = {pc_target_e[31:2], 2'b00};
            else if (!stall_f) m_pc = m_pc + 4;
        end
        #1;
        if (m_live) begin
            chk("pc_f", pc_f, m_pc);
            chk("imem_addr", imem_addr, m_pc);
            chk("instr_d", instr_d, m_instr);
            chk("pc_d", pc_d, m_pcd);
            chk("pc_plus4_d", pc_plus4_d, m_pc4d);
            chk("valid_d", {31'b0, valid_d}, {31'b0, m_valid});
`ifdef FETCH_PERF_CNT_EN
            chk("fetch_cnt", fetch_cnt, m_fcnt);
            chk("stall_cnt", stall_cnt, m_scnt);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        rst = 0; stall_f = 0; stall_d = 0; flush_d = 0; pc_src_e = 0; pc_target_e = 0;
    endtask

    initial begin
        idle(); mem_key = 0; rst = 1;
        tick(); tick();
        chk("rst_pc", pc_f, 32'h0);
        chk("rst_instr", instr_d, 32'h13);
        chk("rst_valid", {31'b0, valid_d}, 32'h0);
        chk("rst_pcd", pc_d, 32'h0);

        idle();
        tick();
        chk("run_pc1", pc_f, 32'h4);
        chk("run_instr1", instr_d, 32'h0);
        chk("run_valid1", {31'b0, valid_d}, 32'h1);
        chk("run_pc4d1", pc_plus4_d, 32'h4);
        tick(); tick(); tick();
        chk("run_pc4", pc_f, 32'h10);
        chk("run_instr4", instr_d, 32'hC);

        stall_f = 1; stall_d = 1;
        tick(); tick();
        chk("stall_pc", pc_f, 32'h10);
        chk("stall_instr", instr_d, 32'hC);
        chk("stall_pcd", pc_d, 32'hC);
        idle();
        tick();
        chk("resume_pc", pc_f, 32'h14);
        chk("resume_pcd", pc_d, 32'h10);

        pc_src_e = 1; pc_target_e = 32'h103; flush_d = 1;
        tick();
        chk("redir_pc", pc_f, 32'h100);
        chk("redir_instr", instr_d, 32'h13);
        chk("redir_valid", {31'b0, valid_d}, 32'h0);
        idle();
        tick();
        chk("redir_pcd", pc_d, 32'h100);

        pc_src_e = 1; pc_target_e = 32'h200; stall_f = 1; flush_d = 1; stall_d = 1;
        tick();
        chk("redir_beats_stall", pc_f, 32'h200);
        chk("flush_beats_stall", instr_d, 32'h13);
        idle();

        pc_src_e = 1; pc_target_e = 32'hFFFF_FFFF; flush_d = 1;
        tick();
        chk("wrap_pc", pc_f, 32'hFFFF_FFFC);
        idle();
        tick();
        chk("wrap_next", pc_f, 32'h0);
        chk("wrap_pc4d", pc_plus4_d, 32'h0);
        chk("wrap_pcd", pc_d, 32'hFFFF_FFFC);

        pc_src_e = 1; pc_target_e = 32'h40; flush_d = 1;
        tick();
        pc_target_e = 32'h80;
        tick();
        chk("double_redir", pc_f, 32'h80);
        idle();

        rst = 1; stall_f = 1; flush_d = 1; stall_d = 1;
        tick();
        chk("mid_rst_pc", pc_f, 32'h0);
        chk("mid_rst_instr", instr_d, 32'h13);
        chk("mid_rst_valid", {31'b0, valid_d}, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("mid_rst_scnt", stall_cnt, 32'h0);
`endif
        idle(); stall_f = 1; stall_d = 1;
        tick(); tick(); tick();
        chk("stall3_pc", pc_f, 32'h0);
`ifdef FETCH_PERF_CNT_EN
        chk("stall3_scnt", stall_cnt, 32'd3);
        chk("stall3_fcnt", fetch_cnt, 32'd0);
`endif

        mem_key = $urandom;
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 99) < 2);
            stall_f     = ($urandom_range(0, 3) == 0);
            stall_d     = ($urandom_range(0, 3) == 0);
            pc_src_e    = ($urandom_range(0, 5) == 0);
            flush_d     = pc_src_e ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 9) == 0);
            pc_target_e = $urandom;
            if (i % 500 == 499) mem_key = $urandom;
            tick();
        end
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
